// File: rtl/dcsformer_pkg.sv
// Shared types and frame geometry for the DCSformer sequencer.
// Index widths are derived here so the datapath and controller agree on them.
package dcsformer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    WLOAD,
    WDRAIN,
    OUT,
    CLEAR
  } state_t;

  localparam int ROWS  = 8;
  localparam int COLS  = 16;
  localparam int WCNT  = 8;

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int OUT_W = $clog2(WCNT);

endpackage

// File: rtl/dcs_delay_line.sv
// Fixed-depth shift register, cleared by reset.
// Aligns load-side strobes with the datapath's accumulate stage.
module dcs_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/dcsformer_seq_ctrl.sv
// Frame sequencer for the DCSformer datapath: sample load, weight load,
// output drain and clear, plus the per-cycle datapath enables and indices.
module dcsformer_seq_ctrl #(
  parameter int ROWS   = dcsformer_pkg::ROWS,
  parameter int COLS   = dcsformer_pkg::COLS,
  parameter int WCNT   = dcsformer_pkg::WCNT,
  parameter int DP_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic                    w_valid,
  input  logic                    o_ready,
  output logic                    w_ready,
  output logic                    o_valid,
  output logic                    busy,
  output logic                    err_drop,
  output logic                    dp_load_en,
  output logic [$clog2(ROWS)-1:0] dp_row_idx,
  output logic [$clog2(COLS)-1:0] dp_col_idx,
  output logic                    dp_acc_en,
  output logic                    dp_acc_first,
  output logic                    dp_w_en,
  output logic [$clog2(WCNT)-1:0] dp_out_sel,
  output logic                    dp_clear
);

  import dcsformer_pkg::*;

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int OW = $clog2(WCNT);

  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
  localparam logic [OW-1:0] WORD_LAST   = OW'(WCNT - 1);
  localparam logic [2:0]    DRAIN_LAST  = 3'(DP_LAT - 1);
  localparam logic [2:0]    WDRAIN_LAST = 3'(DP_LAT);

  state_t        state;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic [OW-1:0] w_cnt;
  logic [OW-1:0] out_cnt;
  logic [2:0]    wait_cnt;
  logic          load_window;
  logic          i_drop;
  logic          w_drop;
  logic [1:0]    acc_d;
  logic [1:0]    acc_q;

  // w_ready is high exactly while in WLOAD, so it doubles as the weight window.
  assign load_window = (state == IDLE) || (state == LOAD);
  assign dp_load_en  = i_valid && load_window;
  assign dp_w_en     = w_valid && w_ready;
  assign i_drop      = i_valid && !load_window;
  assign w_drop      = w_valid && !w_ready;
  assign dp_row_idx  = row_cnt;
  assign dp_col_idx  = col_cnt;
  assign dp_out_sel  = out_cnt;

  assign acc_d        = {dp_load_en, dp_load_en && (col_cnt == '0)};
  assign dp_acc_en    = acc_q[1];
  assign dp_acc_first = acc_q[0];

  dcs_delay_line #(.DEPTH(DP_LAT), .WIDTH(2)) u_acc_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (acc_d),
    .q     (acc_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row_cnt  <= '0;
      col_cnt  <= '0;
      w_cnt    <= '0;
      out_cnt  <= '0;
      wait_cnt <= '0;
      w_ready  <= 1'b0;
      o_valid  <= 1'b0;
      busy     <= 1'b0;
      err_drop <= 1'b0;
      dp_clear <= 1'b0;
    end else begin
      err_drop <= i_drop || w_drop;
      case (state)
        IDLE, LOAD: begin
          if (i_valid) begin
            busy  <= 1'b1;
            state <= LOAD;
            if (col_cnt == COL_LAST) begin
              col_cnt <= '0;
              if (row_cnt == ROW_LAST) begin
                row_cnt  <= '0;
                wait_cnt <= '0;
                state    <= DRAIN;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (wait_cnt == DRAIN_LAST) begin
            wait_cnt <= '0;
            w_ready  <= 1'b1;
            state    <= WLOAD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WLOAD: begin
          if (w_valid) begin
            if (w_cnt == WORD_LAST) begin
              w_cnt   <= '0;
              w_ready <= 1'b0;
              state   <= WDRAIN;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        WDRAIN: begin
          if (wait_cnt == WDRAIN_LAST) begin
            wait_cnt <= '0;
            o_valid  <= 1'b1;
            state    <= OUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        OUT: begin
          if (o_ready) begin
            if (out_cnt == WORD_LAST) begin
              out_cnt  <= '0;
              o_valid  <= 1'b0;
              dp_clear <= 1'b1;
              state    <= CLEAR;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        CLEAR: begin
          dp_clear <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcsformer_seq_ctrl.sv
// Directed bench for dcsformer_seq_ctrl with default geometry (8x16, 8 weights, DP_LAT=2).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_dcsformer_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid, w_valid, o_ready;
  logic       w_ready, o_valid, busy, err_drop;
  logic       dp_load_en, dp_acc_en, dp_acc_first, dp_w_en, dp_clear;
  logic [2:0] dp_row_idx;
  logic [3:0] dp_col_idx;
  logic [2:0] dp_out_sel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcsformer_seq_ctrl #(.ROWS(8), .COLS(16), .WCNT(8), .DP_LAT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .w_valid      (w_valid),
    .o_ready      (o_ready),
    .w_ready      (w_ready),
    .o_valid      (o_valid),
    .busy         (busy),
    .err_drop     (err_drop),
    .dp_load_en   (dp_load_en),
    .dp_row_idx   (dp_row_idx),
    .dp_col_idx   (dp_col_idx),
    .dp_acc_en    (dp_acc_en),
    .dp_acc_first (dp_acc_first),
    .dp_w_en      (dp_w_en),
    .dp_out_sel   (dp_out_sel),
    .dp_clear     (dp_clear)
  );

  task automatic test_reset;
    rst_n = 1'b0; i_valid = 1'b0; w_valid = 1'b0; o_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({w_ready, o_valid, busy, err_drop, dp_load_en, dp_acc_en, dp_acc_first, dp_w_en, dp_clear} !== 9'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, expected 0", {w_ready, o_valid, busy, err_drop, dp_load_en, dp_acc_en, dp_acc_first, dp_w_en, dp_clear});
    end
    vectors++;
    if ({dp_row_idx, dp_col_idx, dp_out_sel} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idx: got %0h, expected 0", {dp_row_idx, dp_col_idx, dp_out_sel});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_contiguous;
    int   first_cnt;
    logic exp_acc, exp_first;
    first_cnt = 0;
    for (int c = 0; c <= 130; c++) begin
      @(negedge clk);
      i_valid = (c < 128);
      #1;
      vectors++;
      if (dp_load_en !== (c < 128)) begin
        miscompares++;
        $display("[TB] FAIL contig_load_en c=%0d: got %b, expected %b", c, dp_load_en, (c < 128));
      end
      if (c < 128) begin
        vectors++;
        if (dp_row_idx !== 3'(c / 16) || dp_col_idx !== 4'(c % 16)) begin
          miscompares++;
          $display("[TB] FAIL contig_idx c=%0d: got %0d/%0d, expected %0d/%0d", c, dp_row_idx, dp_col_idx, c / 16, c % 16);
        end
      end
      exp_acc   = (c >= 2) && (c < 130);
      exp_first = exp_acc && ((c - 2) % 16 == 0);
      vectors++;
      if (dp_acc_en !== exp_acc || dp_acc_first !== exp_first) begin
        miscompares++;
        $display("[TB] FAIL contig_acc c=%0d: got en=%b first=%b, expected en=%b first=%b", c, dp_acc_en, dp_acc_first, exp_acc, exp_first);
      end
      if (dp_acc_first === 1'b1) first_cnt++;
      vectors++;
      if (w_ready !== (c == 130)) begin
        miscompares++;
        $display("[TB] FAIL contig_w_ready c=%0d: got %b, expected %b", c, w_ready, (c == 130));
      end
      if (c > 0) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL contig_busy c=%0d: got %b, expected 1", c, busy);
        end
      end
    end
    vectors++;
    if (first_cnt != 8) begin
      miscompares++;
      $display("[TB] FAIL contig_first_count: got %0d, expected 8", first_cnt);
    end
  endtask

  task automatic test_weights_out;
    int   accepted, cyc, wen_cnt;
    logic ill, prev_ill;
    accepted = 0; cyc = 0; wen_cnt = 0;
    while (accepted < 8 && cyc < 40) begin
      @(negedge clk);
      w_valid = (cyc % 2 == 0);
      #1;
      vectors++;
      if (w_ready !== 1'b1 || dp_w_en !== w_valid) begin
        miscompares++;
        $display("[TB] FAIL wload cyc=%0d: got ready=%b w_en=%b, expected ready=1 w_en=%b", cyc, w_ready, dp_w_en, w_valid);
      end
      if (dp_w_en === 1'b1) wen_cnt++;
      if (w_valid) accepted++;
      cyc++;
    end
    vectors++;
    if (accepted != 8) begin
      miscompares++;
      $display("[TB] FAIL wload_timeout: got %0d weights, expected 8", accepted);
    end
    // Cycle after the last weight: an extra w_valid must be dropped.
    @(negedge clk); w_valid = 1'b1; o_ready = 1'b0; #1;
    vectors++;
    if (w_ready !== 1'b0 || dp_w_en !== 1'b0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wdrain1: got ready=%b w_en=%b o_valid=%b, expected 0/0/0", w_ready, dp_w_en, o_valid);
    end
    @(negedge clk); w_valid = 1'b0; #1;
    vectors++;
    if (err_drop !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wdrain2: got err=%b o_valid=%b, expected 1/0", err_drop, o_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if (err_drop !== 1'b0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wdrain3: got err=%b o_valid=%b, expected 0/0", err_drop, o_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if (o_valid !== 1'b1 || dp_out_sel !== 3'd0 || wen_cnt != 8) begin
      miscompares++;
      $display("[TB] FAIL out_start: got o_valid=%b sel=%0d w_en_count=%0d, expected 1/0/8", o_valid, dp_out_sel, wen_cnt);
    end
    prev_ill = 1'b0;
    for (int w = 0; w < 8; w++) begin
      if (w == 4) begin
        repeat (3) begin
          @(negedge clk); o_ready = 1'b0; #1;
          vectors++;
          if (o_valid !== 1'b1 || dp_out_sel !== 3'd4 || err_drop !== prev_ill) begin
            miscompares++;
            $display("[TB] FAIL out_hold: got o_valid=%b sel=%0d err=%b, expected 1/4/%b", o_valid, dp_out_sel, err_drop, prev_ill);
          end
          prev_ill = 1'b0;
        end
      end
      @(negedge clk);
      ill = (w == 2);
      o_ready = 1'b1; i_valid = ill; w_valid = ill;
      #1;
      vectors++;
      if (o_valid !== 1'b1 || dp_out_sel !== 3'(w) || err_drop !== prev_ill || dp_load_en !== 1'b0 || dp_w_en !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL out_word w=%0d: got o_valid=%b sel=%0d err=%b load=%b w_en=%b, expected 1/%0d/%b/0/0", w, o_valid, dp_out_sel, err_drop, dp_load_en, dp_w_en, w, prev_ill);
      end
      prev_ill = ill;
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); i_valid = 1'b1; w_valid = 1'b0; #1;
    vectors++;
    if (dp_clear !== 1'b1 || o_valid !== 1'b0 || dp_load_en !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clear_cycle: got clear=%b o_valid=%b load=%b busy=%b, expected 1/0/0/1", dp_clear, o_valid, dp_load_en, busy);
    end
  endtask

  task automatic test_gapped;
    int   idx;
    logic exp_err;
    for (int j = 0; j <= 257; j++) begin
      @(negedge clk);
      i_valid = (j < 255) && (j % 2 == 0);
      w_valid = (j == 11);
      #1;
      idx = (j + 1) / 2;
      if (j < 255) begin
        vectors++;
        if (dp_load_en !== i_valid || dp_row_idx !== 3'(idx / 16) || dp_col_idx !== 4'(idx % 16)) begin
          miscompares++;
          $display("[TB] FAIL gap_load j=%0d: got load=%b idx=%0d/%0d, expected %b %0d/%0d", j, dp_load_en, dp_row_idx, dp_col_idx, i_valid, idx / 16, idx % 16);
        end
      end else begin
        vectors++;
        if (w_ready !== (j == 257)) begin
          miscompares++;
          $display("[TB] FAIL gap_w_ready j=%0d: got %b, expected %b", j, w_ready, (j == 257));
        end
      end
      exp_err = (j == 0) || (j == 12);
      vectors++;
      if (err_drop !== exp_err) begin
        miscompares++;
        $display("[TB] FAIL gap_err j=%0d: got %b, expected %b", j, err_drop, exp_err);
      end
      if (j == 0) begin
        vectors++;
        if (dp_clear !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_idle: got clear=%b busy=%b, expected 0/0", dp_clear, busy);
        end
      end
    end
  endtask

  task automatic test_illegal_wload;
    @(negedge clk); i_valid = 1'b1; w_valid = 1'b0; #1;
    vectors++;
    if (dp_load_en !== 1'b0 || w_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wload_ivalid: got load=%b ready=%b, expected 0/1", dp_load_en, w_ready);
    end
    @(negedge clk); i_valid = 1'b0; #1;
    vectors++;
    if (err_drop !== 1'b1 || w_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wload_drop: got err=%b ready=%b busy=%b, expected 1/1/1", err_drop, w_ready, busy);
    end
    @(negedge clk); #1;
    vectors++;
    if (err_drop !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wload_drop_end: got %b, expected 0", err_drop);
    end
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk); rst_n = 1'b0; #1;
    vectors++;
    if (w_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got ready=%b busy=%b, expected 0/0", w_ready, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int s = 0; s < 50; s++) begin
      @(negedge clk); i_valid = 1'b1; #1;
      if (s == 49) begin
        vectors++;
        if (dp_row_idx !== 3'd3 || dp_col_idx !== 4'd1 || busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL mid_sample49: got %0d/%0d busy=%b, expected 3/1 busy=1", dp_row_idx, dp_col_idx, busy);
        end
      end
    end
    @(negedge clk); rst_n = 1'b0; i_valid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({w_ready, o_valid, busy, err_drop, dp_load_en, dp_acc_en, dp_acc_first, dp_w_en, dp_clear, dp_row_idx, dp_col_idx, dp_out_sel} !== 19'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got %b, expected 0", {w_ready, o_valid, busy, err_drop, dp_load_en, dp_acc_en, dp_acc_first, dp_w_en, dp_clear, dp_row_idx, dp_col_idx, dp_out_sel});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); i_valid = 1'b1; #1;
    vectors++;
    if (dp_load_en !== 1'b1 || dp_row_idx !== 3'd0 || dp_col_idx !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_first: got load=%b idx=%0d/%0d, expected 1 0/0", dp_load_en, dp_row_idx, dp_col_idx);
    end
    @(negedge clk); i_valid = 1'b0; #1;
    vectors++;
    if (dp_col_idx !== 4'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_second: got col=%0d busy=%b, expected 1/1", dp_col_idx, busy);
    end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_weights_out();
    test_back_to_back();
    test_gapped();
    test_illegal_wload();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dcsformer_seq_ctrl.md
Name: dcsformer_seq_ctrl

Overview:
- Central sequencer for the DCSformer datapath: Gram-matrix accumulator, average/threshold stage, weight multiply-rotate stage and output mux.
- Owns all frame-level handshakes: input stream, weight request, output drain.
- Drives the datapath with per-cycle enables and indices, so the datapath itself holds no frame control state.
- Sits between the external stream interfaces and the datapath array.

Parameters:
- ROWS, 8, number of input rows (feature vectors) per frame.
- COLS, 16, samples per row; row-major input order.
- WCNT, 8, weight bytes per frame; equals output word count.
- DP_LAT, 2, cycles from an accepted input sample to its accumulate in the datapath; range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input sample strobe; no backpressure
- w_valid  in  1  weight byte valid
- o_ready  in  1  downstream accepts o_data
- w_ready  out  1  controller accepting weights
- o_valid  out  1  output word valid
- busy  out  1  frame in progress (state != IDLE)
- err_drop  out  1  one-cycle pulse: strobe ignored outside its window
- dp_load_en  out  1  shift the accepted sample into the datapath
- dp_row_idx  out  $clog2(ROWS)  row of the current sample
- dp_col_idx  out  $clog2(COLS)  column of the current sample
- dp_acc_en  out  1  accumulate enable, delayed DP_LAT from dp_load_en
- dp_acc_first  out  1  first column of a row, aligned with dp_acc_en
- dp_w_en  out  1  weight multiply/rotate step
- dp_out_sel  out  $clog2(WCNT)  output word select
- dp_clear  out  1  one-cycle clear of accumulators and sample buffer

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset: state=IDLE, all counters 0, every output 0. This holds for reset asserted mid-frame, including during OUT; no partial output follows reset.
- State IDLE:
  - i_valid=1 accepts sample 0 (row 0, col 0) and moves to LOAD.
  - w_valid in IDLE pulses err_drop.
- State LOAD:
  - Each i_valid accepts one sample.
  - Row/col counters advance col-first; col wraps COLS-1 to 0 and increments row.
  - Gaps (i_valid=0) hold the counters.
  - After the ROWS*COLS-th accept, move to DRAIN.
- Load outputs: dp_load_en=i_valid in IDLE/LOAD. dp_row_idx/dp_col_idx show the index of the sample accepted this cycle.
- Accumulate timing: dp_acc_en and dp_acc_first are dp_load_en and (col==0) passed through a DP_LAT-deep delay line. The delay line continues shifting in all states.
- State DRAIN: waits DP_LAT cycles, then moves to WLOAD.
- State WLOAD:
  - w_ready=1.
  - A weight is accepted when w_valid&&w_ready; dp_w_en=1 in the same cycle.
  - After WCNT accepts, w_ready drops the next cycle and the state moves to WDRAIN.
- State WDRAIN: waits DP_LAT+1 cycles for the multiply pipeline, then moves to OUT.
- State OUT:
  - o_valid=1; dp_out_sel=out_cnt, starting at 0.
  - On o_valid&&o_ready, out_cnt increments.
  - With o_ready=0, dp_out_sel and o_valid hold.
  - After the WCNT-th handshake, move to CLEAR.
- State CLEAR: dp_clear=1 for exactly one cycle, then IDLE. i_valid in CLEAR is dropped (err_drop).
- Dropped strobes: i_valid outside IDLE/LOAD and w_valid outside WLOAD are ignored. Each pulses err_drop for one cycle; counters are unchanged.
- Simultaneous events: in the last-weight cycle, w_valid is accepted and the next w_valid is dropped. err_drop is a single pulse even when both strobes are illegal in the same cycle.
- Output registering: all outputs are registered except dp_load_en, dp_row_idx, dp_col_idx, dp_w_en. These are combinational from i_valid/w_valid and registered state.
- Latency, no gaps and o_ready=1: last sample to w_ready rise = DP_LAT+1 cycles; last weight to first o_valid = DP_LAT+2 cycles.

Decomposition:
- Package dcsformer_pkg:
  - state enum {IDLE, LOAD, DRAIN, WLOAD, WDRAIN, OUT, CLEAR}
  - constants ROWS, COLS, WCNT
  - derived index widths
- One sub-module, dcs_delay_line: parameterised DEPTH×WIDTH shift register, async reset to 0. Used for the dp_acc_en/dp_acc_first alignment.

Test Plan:
- Contiguous frame (128 back-to-back i_valid), default params:
  - dp_load_en high 128 cycles.
  - dp_acc_first pulses 8 times, at samples 0,16,…,112, each +2 cycles.
  - w_ready rises 3 cycles after the last sample.
- Gapped input (i_valid every other cycle): row/col hold during gaps; LOAD exits after 255 cycles; row_idx=7, col_idx=15 on the final accept.
- Weights with gaps, then o_ready low for 3 cycles at word 4:
  - dp_w_en pulses exactly 8 times.
  - dp_out_sel holds 4 with o_valid=1 for 3 cycles.
  - dp_clear pulses once after word 7.
- Illegal strobes: i_valid in WLOAD, w_valid in LOAD, both in the same cycle in OUT. Each case gives one err_drop pulse; counters and state unchanged.
- Reset mid-LOAD at sample 50:
  - All outputs 0 and busy=0 next cycle.
  - The following frame's first accept reports row 0, col 0.
- Back-to-back frames: i_valid one cycle after CLEAR is accepted as sample 0 with no err_drop; i_valid during CLEAR is dropped.
